// File: rtl/control_checker.sv
`default_nettype none
// ============================================================================
// Module   : control_checker
// Purpose  : Run-time checker comparing RISC-V control-unit outputs against a
//            per-opcode-class expectation table, with counters and capture.
// Revision : 1.0 - initial release
// ============================================================================
module control_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [6:0]       opcode,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             alu_src,
  input  logic             branch,
  input  logic             jump,
  input  logic             jalr,
  input  logic [1:0]       result_src,
  input  logic             clear,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [2:0]       err_class,
  output logic [6:0]       err_mask,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] viol_count
);

  localparam logic [2:0] c_CLS_R      = 3'd0;
  localparam logic [2:0] c_CLS_I      = 3'd1;
  localparam logic [2:0] c_CLS_LOAD   = 3'd2;
  localparam logic [2:0] c_CLS_STORE  = 3'd3;
  localparam logic [2:0] c_CLS_BRANCH = 3'd4;
  localparam logic [2:0] c_CLS_JAL    = 3'd5;
  localparam logic [2:0] c_CLS_JALR   = 3'd6;
  localparam logic [2:0] c_CLS_OTHER  = 3'd7;

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0] w_in_class;
  logic       w_cmp_valid;
  logic [2:0] w_cmp_class;
  logic [6:0] w_mask;
  logic       w_viol;

  logic             r_err_pulse;
  logic             r_err_sticky;
  logic [2:0]       r_err_class;
  logic [6:0]       r_err_mask;
  logic [CNT_W-1:0] r_check_count;
  logic [CNT_W-1:0] r_viol_count;

  always_comb begin
    w_in_class = c_CLS_OTHER;
    case (opcode)
      7'b0110011: w_in_class = c_CLS_R;
      7'b0010011: w_in_class = c_CLS_I;
      7'b0000011: w_in_class = c_CLS_LOAD;
      7'b0100011: w_in_class = c_CLS_STORE;
      7'b1100011: w_in_class = c_CLS_BRANCH;
      7'b1101111: w_in_class = c_CLS_JAL;
      7'b1100111: w_in_class = c_CLS_JALR;
      default:    w_in_class = c_CLS_OTHER;
    endcase
  end

  // Class travels alongside the instruction so the compare lines up with
  // the control unit's pipelined outputs.
  generate
    if (LATENCY == 0) begin : g_lat0
      assign w_cmp_valid = valid_in;
      assign w_cmp_class = w_in_class;
    end else begin : g_pipe
      logic [LATENCY-1:0] r_dv;
      logic [2:0]         r_dc [LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dv <= '0;
          for (int i = 0; i < LATENCY; i++) r_dc[i] <= 3'd0;
        end else begin
          r_dv[0] <= valid_in;
          r_dc[0] <= w_in_class;
          for (int i = 1; i < LATENCY; i++) begin
            r_dv[i] <= r_dv[i-1];
            r_dc[i] <= r_dc[i-1];
          end
        end
      end

      assign w_cmp_valid = r_dv[LATENCY-1];
      assign w_cmp_class = r_dc[LATENCY-1];
    end
  endgenerate

  // Mask bits: [0] rw, [1] mw, [2] as, [3] rs, [4] br, [5] j, [6] jr.
  // Don't-care fields are tied to 0.
  always_comb begin
    w_mask = 7'd0;
    case (w_cmp_class)
      c_CLS_R:      w_mask = {jalr, jump, branch, result_src != 2'b00,
                              alu_src, mem_write, ~reg_write};
      c_CLS_I:      w_mask = {jalr, jump, branch, result_src != 2'b00,
                              ~alu_src, mem_write, ~reg_write};
      c_CLS_LOAD:   w_mask = {jalr, jump, branch, result_src != 2'b01,
                              ~alu_src, mem_write, ~reg_write};
      c_CLS_STORE:  w_mask = {jalr, jump, branch, 1'b0,
                              ~alu_src, ~mem_write, reg_write};
      c_CLS_BRANCH: w_mask = {jalr, jump, ~branch, 1'b0,
                              1'b0, mem_write, reg_write};
      c_CLS_JAL:    w_mask = {jalr, ~jump, branch, result_src != 2'b10,
                              1'b0, mem_write, ~reg_write};
      c_CLS_JALR:   w_mask = {~jalr, jump, branch, result_src != 2'b10,
                              ~alu_src, mem_write, ~reg_write};
      default:      w_mask = {jalr, jump, branch, 1'b0,
                              1'b0, mem_write, reg_write};
    endcase
  end

  assign w_viol = w_cmp_valid & (w_mask != 7'd0);

  // clear beats same-cycle increments and capture, but err_pulse still
  // reports the compare so no violation goes unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_class   <= 3'd0;
      r_err_mask    <= 7'd0;
      r_check_count <= '0;
      r_viol_count  <= '0;
    end else begin
      r_err_pulse <= w_viol;
      if (clear) begin
        r_err_sticky  <= 1'b0;
        r_err_class   <= 3'd0;
        r_err_mask    <= 7'd0;
        r_check_count <= '0;
        r_viol_count  <= '0;
      end else begin
        if (w_cmp_valid && (r_check_count != c_CNT_MAX))
          r_check_count <= r_check_count + c_CNT_ONE;
        if (w_viol && (r_viol_count != c_CNT_MAX))
          r_viol_count <= r_viol_count + c_CNT_ONE;
        if (w_viol && !r_err_sticky) begin
          r_err_sticky <= 1'b1;
          r_err_class  <= w_cmp_class;
          r_err_mask   <= w_mask;
        end
      end
    end
  end

  assign err_pulse   = r_err_pulse;
  assign err_sticky  = r_err_sticky;
  assign err_class   = r_err_class;
  assign err_mask    = r_err_mask;
  assign check_count = r_check_count;
  assign viol_count  = r_viol_count;

endmodule
`default_nettype wire

// File: tb/tb_control_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_checker
// Purpose  : Self-checking bench; three checker instances (LATENCY 1/0/3)
//            against a table-driven reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       clear = 1'b0;
  logic [7:0] ctl0 = 8'd0, ctl1 = 8'd0, ctl2 = 8'd0;

  logic        pulse0, pulse1, pulse2;
  logic        st0, st1, st2;
  logic [2:0]  cls0, cls1, cls2;
  logic [6:0]  msk0, msk1, msk2;
  logic [15:0] cc0, vc0, cc1, vc1;
  logic [3:0]  cc2, vc2;

  always #5 clk = ~clk;

  // ctl bits: [0] rw, [1] mw, [2] as, [4:3] rs, [5] br, [6] j, [7] jr
  control_checker #(.LATENCY(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
    .reg_write(ctl0[0]), .mem_write(ctl0[1]), .alu_src(ctl0[2]),
    .branch(ctl0[5]), .jump(ctl0[6]), .jalr(ctl0[7]), .result_src(ctl0[4:3]),
    .clear(clear), .err_pulse(pulse0), .err_sticky(st0), .err_class(cls0),
    .err_mask(msk0), .check_count(cc0), .viol_count(vc0));

  control_checker #(.LATENCY(0), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
    .reg_write(ctl1[0]), .mem_write(ctl1[1]), .alu_src(ctl1[2]),
    .branch(ctl1[5]), .jump(ctl1[6]), .jalr(ctl1[7]), .result_src(ctl1[4:3]),
    .clear(clear), .err_pulse(pulse1), .err_sticky(st1), .err_class(cls1),
    .err_mask(msk1), .check_count(cc1), .viol_count(vc1));

  control_checker #(.LATENCY(3), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
    .reg_write(ctl2[0]), .mem_write(ctl2[1]), .alu_src(ctl2[2]),
    .branch(ctl2[5]), .jump(ctl2[6]), .jalr(ctl2[7]), .result_src(ctl2[4:3]),
    .clear(clear), .err_pulse(pulse2), .err_sticky(st2), .err_class(cls2),
    .err_mask(msk2), .check_count(cc2), .viol_count(vc2));

  // Expected field values per class (rw, mw, as, rs, br, j, jr); -1 = don't care
  int EXP [8][7] = '{
    '{1, 0,  0,  0, 0, 0, 0},
    '{1, 0,  1,  0, 0, 0, 0},
    '{1, 0,  1,  1, 0, 0, 0},
    '{0, 1,  1, -1, 0, 0, 0},
    '{0, 0, -1, -1, 1, 0, 0},
    '{1, 0, -1,  2, 0, 1, 0},
    '{1, 0,  1,  2, 0, 0, 1},
    '{0, 0, -1, -1, 0, 0, 0}};
  logic [6:0] OPC [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b1100111};
  int LAT  [3] = '{1, 0, 3};
  int MAXC [3] = '{65535, 65535, 15};

  localparam int HMAX = 2048;
  logic       hv   [HMAX];
  logic [6:0] hop  [HMAX];
  logic [7:0] hctl [HMAX];
  logic       hclr [HMAX];
  logic       hrst [HMAX];
  int cyc = 0;

  int m_pulse [3], m_st [3], m_cls [3], m_msk [3], m_cc [3], m_vc [3];
  int checks = 0;
  int errors = 0;

  function automatic int cls_of(logic [6:0] op);
    for (int i = 0; i < 7; i++) if (OPC[i] == op) return i;
    return 7;
  endfunction

  function automatic int fld(logic [7:0] c, int i);
    case (i)
      0: return int'(c[0]);
      1: return int'(c[1]);
      2: return int'(c[2]);
      3: return int'(c[4:3]);
      4: return int'(c[5]);
      5: return int'(c[6]);
      default: return int'(c[7]);
    endcase
  endfunction

  function automatic logic [7:0] good_ctl(int c);
    int v [7];
    for (int i = 0; i < 7; i++) begin
      if (EXP[c][i] < 0) v[i] = (i == 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1));
      else               v[i] = EXP[c][i];
    end
    return {v[6][0], v[5][0], v[4][0], v[3][1:0], v[2][0], v[1][0], v[0][0]};
  endfunction

  function automatic int exp_mask(logic [6:0] op, logic [7:0] c);
    int k = cls_of(op);
    int m = 0;
    for (int i = 0; i < 7; i++)
      if (EXP[k][i] >= 0 && fld(c, i) != EXP[k][i]) m = m | (1 << i);
    return m;
  endfunction

  function automatic logic [7:0] dly(int l);
    return (cyc - l >= 0) ? hctl[cyc - l] : 8'h00;
  endfunction

  // Reference behaviour for one instance at the edge ending cycle 'cyc'.
  task automatic m_step(input int k);
    int s = cyc - LAT[k];
    bit live = 1'b0;
    int m = 0;
    if (s >= 0 && hv[s]) begin
      live = 1'b1;
      for (int c = s; c < cyc; c++) if (hrst[c]) live = 1'b0;
    end
    if (live) m = exp_mask(hop[s], hctl[s]);
    if (hrst[cyc]) begin
      m_pulse[k] = 0; m_st[k] = 0; m_cls[k] = 0; m_msk[k] = 0; m_cc[k] = 0; m_vc[k] = 0;
    end else begin
      m_pulse[k] = (live && m != 0) ? 1 : 0;
      if (hclr[cyc]) begin
        m_st[k] = 0; m_cls[k] = 0; m_msk[k] = 0; m_cc[k] = 0; m_vc[k] = 0;
      end else begin
        if (live && m_cc[k] < MAXC[k]) m_cc[k]++;
        if (m_pulse[k] == 1 && m_vc[k] < MAXC[k]) m_vc[k]++;
        if (m_pulse[k] == 1 && m_st[k] == 0) begin
          m_st[k] = 1; m_cls[k] = cls_of(hop[s]); m_msk[k] = m;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_dut(input int k, input logic p, input logic st, input logic [2:0] cl,
                           input logic [6:0] ms, input logic [31:0] cc, input logic [31:0] vc);
    chk($sformatf("d%0d err_pulse", k),   32'(p),  32'(m_pulse[k]));
    chk($sformatf("d%0d err_sticky", k),  32'(st), 32'(m_st[k]));
    chk($sformatf("d%0d err_class", k),   32'(cl), 32'(m_cls[k]));
    chk($sformatf("d%0d err_mask", k),    32'(ms), 32'(m_msk[k]));
    chk($sformatf("d%0d check_count", k), cc,      32'(m_cc[k]));
    chk($sformatf("d%0d viol_count", k),  vc,      32'(m_vc[k]));
  endtask

  task automatic step(input bit v, input logic [6:0] op, input logic [7:0] c,
                      input bit clr, input bit rs);
    if (cyc >= HMAX) begin
      $display("FAIL history: cycle budget exceeded");
      $fatal(1, "history overflow");
    end
    hv[cyc] = v; hop[cyc] = op; hctl[cyc] = c; hclr[cyc] = clr; hrst[cyc] = rs;
    valid_in = v; opcode = op; clear = clr; rst = rs;
    ctl0 = dly(LAT[0]); ctl1 = dly(LAT[1]); ctl2 = dly(LAT[2]);
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_step(k);
    #1;
    check_dut(0, pulse0, st0, cls0, msk0, 32'(cc0), 32'(vc0));
    check_dut(1, pulse1, st1, cls1, msk1, 32'(cc1), 32'(vc1));
    check_dut(2, pulse2, st2, cls2, msk2, 32'(cc2), 32'(vc2));
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    step(1'b0, 7'd0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 7'd0, 8'd0, 1'b0, 1'b1);
    chk("reset check_count", 32'(cc0), 32'd0);
    chk("reset err_sticky",  32'(st0), 32'd0);

    // Seven correct back-to-back instructions
    for (int c = 0; c < 7; c++) step(1'b1, OPC[c], good_ctl(c), 1'b0, 1'b0);
    idle(4);
    chk("seq7 d0 check_count", 32'(cc0), 32'd7);
    chk("seq7 d0 viol_count",  32'(vc0), 32'd0);
    chk("seq7 d0 err_sticky",  32'(st0), 32'd0);
    chk("seq7 d1 check_count", 32'(cc1), 32'd7);
    chk("seq7 d1 viol_count",  32'(vc1), 32'd0);

    // STORE with reg_write set, then JAL missing jump
    step(1'b1, OPC[3], good_ctl(3) | 8'h01, 1'b0, 1'b0);
    idle(4);
    chk("store d0 err_class",  32'(cls0), 32'd3);
    chk("store d0 err_mask",   32'(msk0), 32'h01);
    chk("store d0 viol_count", 32'(vc0),  32'd1);
    step(1'b1, OPC[5], good_ctl(5) & 8'hBF, 1'b0, 1'b0);
    idle(4);
    chk("jal d0 viol_count", 32'(vc0),  32'd2);
    chk("jal d0 err_class",  32'(cls0), 32'd3);
    chk("jal d0 err_mask",   32'(msk0), 32'h01);

    // OTHER opcode: don't-cares tolerated, branch flagged
    step(1'b0, 7'd0, 8'd0, 1'b1, 1'b0);
    step(1'b1, 7'b1110011, 8'b0001_1100, 1'b0, 1'b0);
    idle(4);
    chk("other ok d0 viol_count", 32'(vc0), 32'd0);
    chk("other ok d0 err_sticky", 32'(st0), 32'd0);
    step(1'b1, 7'b1110011, 8'b0010_0000, 1'b0, 1'b0);
    idle(4);
    chk("other br d0 err_mask",  32'(msk0), 32'h10);
    chk("other br d0 err_class", 32'(cls0), 32'd7);

    // Saturation of the 4-bit counters
    step(1'b0, 7'd0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      int c = int'($urandom_range(0, 6));
      step(1'b1, OPC[c], good_ctl(c), 1'b0, 1'b0);
    end
    idle(4);
    chk("sat d2 check_count", 32'(cc2), 32'd15);
    chk("sat d0 check_count", 32'(cc0), 32'd20);

    // clear coinciding with a violation on the LATENCY=0 instance
    step(1'b1, OPC[3], good_ctl(3) | 8'h01, 1'b1, 1'b0);
    chk("clrviol d1 viol_count",  32'(vc1),    32'd0);
    chk("clrviol d1 check_count", 32'(cc1),    32'd0);
    chk("clrviol d1 err_sticky",  32'(st1),    32'd0);
    chk("clrviol d1 err_pulse",   32'(pulse1), 32'd1);
    idle(4);

    // rst discards instructions in flight on the LATENCY=3 instance
    step(1'b1, OPC[0], good_ctl(0) | 8'h02, 1'b0, 1'b0);
    step(1'b1, OPC[4], good_ctl(4) & 8'hDF, 1'b0, 1'b0);
    step(1'b0, 7'd0, 8'd0, 1'b0, 1'b1);
    idle(5);
    chk("rstflight d2 check_count", 32'(cc2), 32'd0);
    chk("rstflight d2 err_sticky",  32'(st2), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      bit v = ($urandom_range(0, 3) != 0);
      int c = int'($urandom_range(0, 7));
      logic [6:0] op;
      logic [7:0] cv;
      logic [7:0] flip;
      if (c < 7) op = OPC[c];
      else op = 7'($urandom_range(0, 127));
      cv = good_ctl(cls_of(op));
      if ($urandom_range(0, 5) == 0) begin
        flip = 8'h01 << $urandom_range(0, 7);
        cv = cv ^ flip;
      end
      step(v, op, cv, ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
